// File: rtl/freq_bin_streamer_pkg.sv
// rtl/freq_bin_streamer_pkg.sv - shared state encodings and frame constants for freq_bin_streamer
package freq_bin_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT     = 3'd3,
    ST_SEND_HI  = 3'd4,
    ST_SEND_LO  = 3'd5,
    ST_CHECKSUM = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam logic [7:0] FRAME_HEADER  = 8'hA5;
  localparam int         BYTES_PER_BIN = 2;

endpackage

// File: rtl/freq_bin_streamer.sv
// rtl/freq_bin_streamer.sv - reads the bin BRAM after an SDFT update and streams it as a checksummed byte frame
module freq_bin_streamer
  import freq_bin_streamer_pkg::*;
#(
  parameter int         freq_bins  = 16,
  parameter int         data_width = 16,
  parameter int         addr_width = 4,
  parameter logic [7:0] header     = FRAME_HEADER
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  ram_r_en,
  output logic [addr_width-1:0] ram_addr,
  input  logic [data_width-1:0] ram_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            dropped
);

  state_t                state_q, state_d;
  logic [data_width-1:0] word_q, word_d;
  logic [7:0]            chk_q, chk_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [7:0]            dropped_q, dropped_d;
  logic                  xfer;

  assign xfer     = tx_valid && tx_ready;
  assign ram_addr = addr_q;
  assign dropped  = dropped_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      chk_q     <= '0;
      addr_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      addr_q    <= addr_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    chk_d     = chk_q;
    addr_d    = addr_q;
    dropped_d = dropped_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    ram_r_en  = 1'b0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;

    // Any start outside IDLE, including the DONE cycle, is dropped and counted.
    if (start && (state_q != ST_IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chk_d   = '0;
          addr_d  = '0;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = header;
        if (xfer) state_d = ST_READ;
      end
      ST_READ: begin
        ram_r_en = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        word_d  = ram_data;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[BYTES_PER_BIN*8-1 -: 8];
        if (xfer) begin
          chk_d   = chk_q ^ tx_data;
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (xfer) begin
          chk_d = chk_q ^ tx_data;
          if (addr_q == addr_width'(freq_bins - 1)) begin
            state_d = ST_CHECKSUM;
          end else begin
            addr_d  = addr_q + addr_width'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_CHECKSUM: begin
        tx_valid = 1'b1;
        tx_data  = chk_q;
        if (xfer) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
